z80_io_cycle_sequencer: RTL and testbench
=========================================

Name: z80_io_cycle_sequencer

Overview:
Sequences every Z80 I/O cycle on the board's 8-bit I/O space. It decodes the port address into one of four device slots and drives the per-slot chip select. It stretches the cycle with WAIT from a programmed wait-state count, optionally followed by a device ready handshake bounded by a timeout. Each slot's configuration is CPU-programmable through a small register port. Sits between the Z80 bus interface and the I/O peripherals.

Parameters:
DEV_ADDR_HI, 7, MSB of the 2-bit slot field in i_addr; slot = i_addr[DEV_ADDR_HI -: 2]
TIMEOUT_CYCLES, 255, max i_clk cycles spent in READY before forced completion (1..255)
RESET_CFG, 8'h08, reset value of every slot config register

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous active-high reset
i_iorq_n  in  1  Z80 IORQ, active low
i_m1_n  in  1  Z80 M1; IORQ with M1 low (interrupt acknowledge) is ignored
i_addr  in  8  Z80 A[7:0]
i_dev_ready  in  4  per-slot ready, active high
i_cfg_cs_n  in  1  config register select, active low
i_cfg_wr_n  in  1  config write strobe, active low
i_cfg_addr  in  2  config register index (slot)
i_cfg_data  in  8  config write data
o_cfg_data  out  8  config read data for i_cfg_addr
o_device  out  2  latched slot of the current or last cycle
o_dev_cs_n  out  4  per-slot chip select, active low
o_wait  out  1  1 = hold Z80 (board inverts to WAIT_n)
o_busy  out  1  1 while state != IDLE

Behaviour:
- Config reg per slot: [1:0] wait states WS, [2] ready enable RE, [3] slot enable EN, [6:4] reads 0, [7] sticky timeout flag TO (read-only).
- Config write when ~i_cfg_cs_n & ~i_cfg_wr_n at posedge: bits[3:0] <= data[3:0]; data[7]=1 clears TO. If timeout set and clear coincide, set wins.
- o_cfg_data = {TO, 3'b000, cfg[i_cfg_addr][3:0]}; combinational.
- Trigger = i_iorq_n low & i_m1_n high & i_iorq_n high at previous posedge (registered copy, reset value 1).
- At trigger: latch slot, WS, RE, EN; counter <= WS. Config writes during a cycle affect only later cycles.
- FSM states: IDLE, COUNT, READY, DONE.
  - IDLE: on trigger, go to COUNT if EN, else DONE (no CS, no wait).
  - COUNT: counter decrements each clock while nonzero. At zero, go to READY if RE (timeout counter <= 0), else DONE.
  - READY: timeout counter increments each clock. Sampled i_dev_ready[slot]=1 -> DONE. Timeout counter reaches TIMEOUT_CYCLES-1 without ready -> set TO[slot], go to DONE.
  - DONE: hold until i_iorq_n high.
  - Any state: sampled i_iorq_n high -> IDLE next clock (abort; no TO set).
- o_wait = ~i_iorq_n & ((COUNT & counter!=0) | READY). Registered terms are gated combinationally by i_iorq_n.
- Wait duration: WS=n with RE=0 gives exactly n clocks of o_wait high, starting the clock after the trigger posedge.
- o_dev_cs_n[k] = ~(sel_reg & slot==k) | i_iorq_n, where sel_reg is set at an enabled trigger and cleared on IDLE. Exactly one or zero bits are low.
- Reset: state IDLE; all cfg = RESET_CFG; TO flags 0; counters 0; o_device 0. Outputs at reset: o_wait 0, o_dev_cs_n 4'hF, o_busy 0. Reset mid-cycle drops wait and CS immediately (asynchronous).
- A new trigger requires i_iorq_n to return high first; back-to-back cycles with one idle clock between them are handled.

Test Plan:
- Reset defaults: after reset, read each cfg -> 8'h08. Then IORQ at addr 8'h40 -> o_dev_cs_n=4'b1101, o_device=1, o_wait never high.
- Wait-state count: write cfg[2]=8'h0B (EN, WS=3), IORQ at addr 8'h80 -> o_wait high exactly 3 clocks, o_dev_cs_n=4'b1011 until IORQ rises.
- Ready handshake: cfg[3]=8'h0D (EN, RE, WS=1), i_dev_ready[3] raised 5 clocks after trigger -> wait 1 + ready clocks then drop; TO[3] stays 0.
- Timeout: TIMEOUT_CYCLES=4, cfg[0]=8'h0C, ready never asserted -> wait drops after the count plus 4 clocks; cfg[0] reads 8'h8C. Write 8'h8C -> reads 8'h0C.
- Disabled slot and interrupt-acknowledge: cfg[1]=8'h00, IORQ at 8'h40 -> o_dev_cs_n=4'hF, no wait. IORQ with M1 low -> o_busy stays 0.
- Abort/reset: WS=3 cycle with IORQ rising after 1 wait clock -> o_wait 0 same cycle, IDLE next clock. Assert i_reset mid-READY -> o_wait 0 and o_dev_cs_n=4'hF immediately.

Source files
------------

// File: rtl/z80_io_cycle_sequencer_if.sv
// z80_io_cycle_sequencer_if
// Groups the Z80 I/O bus, device ready/select lines and the config register
// port of the I/O cycle sequencer.
//   i_iorq_n, i_m1_n, i_addr : Z80 bus inputs
//   i_dev_ready              : per-slot device ready, active high
//   i_cfg_*                  : config register select/write/index/data
//   o_cfg_data               : config read data for i_cfg_addr
//   o_device, o_dev_cs_n     : latched slot and per-slot chip select
//   o_wait, o_busy           : Z80 hold request and sequencer busy
// slave modport = the sequencer, master modport = the driving side.
interface z80_io_cycle_sequencer_if;
  logic       i_iorq_n;
  logic       i_m1_n;
  logic [7:0] i_addr;
  logic [3:0] i_dev_ready;
  logic       i_cfg_cs_n;
  logic       i_cfg_wr_n;
  logic [1:0] i_cfg_addr;
  logic [7:0] i_cfg_data;
  logic [7:0] o_cfg_data;
  logic [1:0] o_device;
  logic [3:0] o_dev_cs_n;
  logic       o_wait;
  logic       o_busy;

  modport slave (
    input  i_iorq_n, i_m1_n, i_addr, i_dev_ready,
           i_cfg_cs_n, i_cfg_wr_n, i_cfg_addr, i_cfg_data,
    output o_cfg_data, o_device, o_dev_cs_n, o_wait, o_busy
  );

  modport master (
    output i_iorq_n, i_m1_n, i_addr, i_dev_ready,
           i_cfg_cs_n, i_cfg_wr_n, i_cfg_addr, i_cfg_data,
    input  o_cfg_data, o_device, o_dev_cs_n, o_wait, o_busy
  );
endinterface

// File: rtl/z80_io_cycle_sequencer.sv
// z80_io_cycle_sequencer
// Sequences Z80 I/O cycles: decodes the port address into one of four slots,
// drives that slot's chip select, and stretches the cycle with WAIT for a
// programmed number of wait states, optionally followed by a device ready
// handshake bounded by TIMEOUT_CYCLES.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous active-high reset
//   bus     : z80_io_cycle_sequencer_if.slave (bus, config port, outputs)
// Config register per slot: [1:0] WS, [2] RE, [3] EN, [7] sticky TO.
module z80_io_cycle_sequencer #(
  parameter int         DEV_ADDR_HI    = 7,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] RESET_CFG      = 8'h08
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  z80_io_cycle_sequencer_if.slave         bus
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_READY, S_DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          r_state, w_next;
  logic [3:0][3:0] r_cfg;
  logic [3:0]      r_to;
  logic            r_iorq_prev;
  logic [1:0]      r_slot;
  logic [1:0]      r_cnt;
  logic            r_re;
  logic            r_sel;
  logic [7:0]      r_tcnt;

  logic       w_trigger;
  logic       w_cfg_wr;
  logic [1:0] w_addr_slot;
  logic [3:0] w_trig_cfg;
  logic       w_ready;
  logic       w_timeout;
  logic       w_unused;

  // A cycle starts only on the falling edge of IORQ outside interrupt acknowledge
  assign w_trigger   = ~bus.i_iorq_n & bus.i_m1_n & r_iorq_prev;
  assign w_cfg_wr    = ~bus.i_cfg_cs_n & ~bus.i_cfg_wr_n;
  assign w_addr_slot = bus.i_addr[DEV_ADDR_HI -: 2];
  assign w_trig_cfg  = r_cfg[w_addr_slot];
  assign w_ready     = bus.i_dev_ready[r_slot];
  // Ready wins over timeout when both land on the same clock
  assign w_timeout   = (r_state == S_READY) & ~bus.i_iorq_n & ~w_ready &
                       (r_tcnt == TO_LAST);
  assign w_unused    = ^{bus.i_addr, bus.i_cfg_data};

  always_comb begin
    w_next = r_state;
    if (bus.i_iorq_n) begin
      w_next = S_IDLE;              // IORQ released: end or abort the cycle
    end else begin
      case (r_state)
        S_IDLE:  if (w_trigger) w_next = w_trig_cfg[3] ? S_COUNT : S_DONE;
        S_COUNT: if (r_cnt == 2'd0) w_next = r_re ? S_READY : S_DONE;
        S_READY: if (w_ready || (r_tcnt == TO_LAST)) w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_iorq_prev <= 1'b1;
      r_slot      <= 2'd0;
      r_cnt       <= 2'd0;
      r_re        <= 1'b0;
      r_sel       <= 1'b0;
      r_tcnt      <= 8'd0;
    end else begin
      r_state     <= w_next;
      r_iorq_prev <= bus.i_iorq_n;
      if ((r_state == S_IDLE) && w_trigger) begin
        // Snapshot the slot config so later writes only affect later cycles
        r_slot <= w_addr_slot;
        r_cnt  <= w_trig_cfg[1:0];
        r_re   <= w_trig_cfg[2];
        r_sel  <= w_trig_cfg[3];
      end else begin
        if (w_next == S_IDLE) r_sel <= 1'b0;
        if ((r_state == S_COUNT) && (r_cnt != 2'd0)) r_cnt <= r_cnt - 2'd1;
      end
      if (r_state == S_COUNT)      r_tcnt <= 8'd0;
      else if (r_state == S_READY) r_tcnt <= r_tcnt + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < 4; k++) r_cfg[k] <= RESET_CFG[3:0];
      r_to <= 4'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_cfg_wr && (bus.i_cfg_addr == 2'(k))) r_cfg[k] <= bus.i_cfg_data[3:0];
        // Timeout set has priority over a coincident software clear
        if (w_timeout && (r_slot == 2'(k)))
          r_to[k] <= 1'b1;
        else if (w_cfg_wr && (bus.i_cfg_addr == 2'(k)) && bus.i_cfg_data[7])
          r_to[k] <= 1'b0;
      end
    end
  end

  assign bus.o_cfg_data = {r_to[bus.i_cfg_addr], 3'b000, r_cfg[bus.i_cfg_addr]};
  assign bus.o_device   = r_slot;
  assign bus.o_busy     = (r_state != S_IDLE);
  // IORQ gates the registered terms so an abort drops WAIT/CS in the same cycle
  assign bus.o_wait     = ~bus.i_iorq_n &
                          (((r_state == S_COUNT) && (r_cnt != 2'd0)) || (r_state == S_READY));

  for (genvar k = 0; k < 4; k++) begin : g_cs
    assign bus.o_dev_cs_n[k] = ~(r_sel & (r_slot == 2'(k))) | bus.i_iorq_n;
  end

endmodule

// File: tb/tb_z80_io_cycle_sequencer.sv
module tb_z80_io_cycle_sequencer;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  z80_io_cycle_sequencer_if bus();

  z80_io_cycle_sequencer #(.DEV_ADDR_HI(7), .TIMEOUT_CYCLES(T), .RESET_CFG(8'h08)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus.slave)
  );

  logic [3:0] m_cfg [4];
  bit         m_to  [4];
  logic [1:0] m_dev;
  int checks = 0;
  int failures = 0;

  // Reference: wait-state clocks 1..WS after the trigger, one clock with the
  // count at zero, then READY clocks until ready is seen or T clocks elapse.
  task automatic run_txn(input logic [7:0] addr, input logic m1, input int hold,
                         input int rdy_at, input logic [3:0] noise);
    int slot, ws, ready_c, exit_c;
    bit trig, en, re, to_hit, e_busy, e_wait;
    logic [3:0] e_cs;
    @(negedge clk);
    slot    = int'(addr[7:6]);
    trig    = m1;
    en      = trig && m_cfg[slot][3];
    ws      = int'(m_cfg[slot][1:0]);
    re      = m_cfg[slot][2];
    ready_c = (rdy_at > ws + 2) ? rdy_at : ws + 2;
    to_hit  = en && re && (ready_c > ws + 1 + T);
    exit_c  = to_hit ? ws + 1 + T : ready_c;
    if (trig) m_dev = 2'(slot);
    bus.i_addr      = addr;
    bus.i_m1_n      = m1;
    bus.i_dev_ready = noise & ~(4'b0001 << slot);
    bus.i_iorq_n    = 1'b0;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      e_wait = en && ((c <= ws) || (re && c >= ws + 2 && c <= exit_c));
      e_busy = trig;
      e_cs   = en ? ~(4'b0001 << slot) : 4'hF;
      checks += 4;
      if (bus.o_wait !== e_wait) begin
        failures++; $display("FAIL txn_wait a=%h c=%0d got=%b exp=%b", addr, c, bus.o_wait, e_wait);
      end
      if (bus.o_busy !== e_busy) begin
        failures++; $display("FAIL txn_busy a=%h c=%0d got=%b exp=%b", addr, c, bus.o_busy, e_busy);
      end
      if (bus.o_dev_cs_n !== e_cs) begin
        failures++; $display("FAIL txn_cs a=%h c=%0d got=%b exp=%b", addr, c, bus.o_dev_cs_n, e_cs);
      end
      if (bus.o_device !== m_dev) begin
        failures++; $display("FAIL txn_dev a=%h c=%0d got=%0d exp=%0d", addr, c, bus.o_device, m_dev);
      end
      if (c == rdy_at) bus.i_dev_ready[slot] = 1'b1;
      if (c == hold) begin
        bus.i_iorq_n = 1'b1;
        #1;
        checks += 2;
        if (bus.o_wait !== 1'b0) begin
          failures++; $display("FAIL release_wait a=%h got=%b exp=0", addr, bus.o_wait);
        end
        if (bus.o_dev_cs_n !== 4'hF) begin
          failures++; $display("FAIL release_cs a=%h got=%b exp=1111", addr, bus.o_dev_cs_n);
        end
      end
    end
    if (to_hit && (ws + 1 + T <= hold - 1)) m_to[slot] = 1'b1;
    bus.i_dev_ready = 4'h0;
    bus.i_m1_n      = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [7:0] data);
    @(negedge clk);
    bus.i_cfg_cs_n = 1'b0; bus.i_cfg_wr_n = 1'b0;
    bus.i_cfg_addr = idx;  bus.i_cfg_data = data;
    @(negedge clk);
    bus.i_cfg_cs_n = 1'b1; bus.i_cfg_wr_n = 1'b1;
    m_cfg[idx] = data[3:0];
    if (data[7]) m_to[idx] = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin m_cfg[k] = 4'h8; m_to[k] = 1'b0; end
    m_dev = 2'd0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (bus.o_wait !== 1'b0) begin failures++; $display("FAIL reset_wait got=%b exp=0", bus.o_wait); end
    if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    if (bus.o_dev_cs_n !== 4'hF) begin failures++; $display("FAIL reset_cs got=%b exp=1111", bus.o_dev_cs_n); end
    if (bus.o_device !== 2'd0) begin failures++; $display("FAIL reset_dev got=%0d exp=0", bus.o_device); end
    for (int k = 0; k < 4; k++) begin
      bus.i_cfg_addr = 2'(k); #1;
      e = {m_to[k], 3'b000, m_cfg[k]};
      checks++;
      if (bus.o_cfg_data !== e) begin failures++; $display("FAIL reset_cfg%0d got=%h exp=%h", k, bus.o_cfg_data, e); end
    end
    @(negedge clk);
    rst = 1'b0;
    run_txn(8'h40, 1'b1, 4, 99, 4'h0);
  endtask

  task automatic test_wait_states();
    cfg_write(2'd2, 8'h0B);
    run_txn(8'h80, 1'b1, 6, 99, 4'h0);
  endtask

  task automatic test_ready();
    logic [7:0] e;
    cfg_write(2'd3, 8'h0D);
    run_txn(8'hC0, 1'b1, 10, 5, 4'h7);
    bus.i_cfg_addr = 2'd3; #1;
    e = {m_to[3], 3'b000, m_cfg[3]};
    checks++;
    if (bus.o_cfg_data !== e) begin failures++; $display("FAIL ready_cfg3 got=%h exp=%h", bus.o_cfg_data, e); end
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    cfg_write(2'd0, 8'h0C);
    run_txn(8'h00, 1'b1, 10, 99, 4'hE);
    bus.i_cfg_addr = 2'd0; #1;
    e = {m_to[0], 3'b000, m_cfg[0]};
    checks++;
    if (bus.o_cfg_data !== e) begin failures++; $display("FAIL timeout_set got=%h exp=%h", bus.o_cfg_data, e); end
    cfg_write(2'd0, 8'h8C);
    bus.i_cfg_addr = 2'd0; #1;
    e = {m_to[0], 3'b000, m_cfg[0]};
    checks++;
    if (bus.o_cfg_data !== e) begin failures++; $display("FAIL timeout_clr got=%h exp=%h", bus.o_cfg_data, e); end
  endtask

  task automatic test_disabled_intack();
    cfg_write(2'd1, 8'h00);
    run_txn(8'h40, 1'b1, 4, 99, 4'h0);
    run_txn(8'h40, 1'b0, 4, 99, 4'h0);
    cfg_write(2'd1, 8'h08);
    run_txn(8'h7F, 1'b0, 3, 99, 4'h0);
  endtask

  task automatic test_abort();
    run_txn(8'h80, 1'b1, 1, 99, 4'h0);
    @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", bus.o_busy); end
    run_txn(8'h00, 1'b1, 4, 99, 4'h0);   // abort inside READY: no timeout flag
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int s;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0)
        cfg_write(2'($urandom_range(0, 3)), 8'($urandom));
      s = $urandom_range(0, 3);
      run_txn({2'(s), 6'($urandom)}, ($urandom_range(0, 7) != 0), $urandom_range(1, 14),
              ($urandom_range(0, 3) == 0) ? 99 : $urandom_range(1, 12), 4'($urandom));
      bus.i_cfg_addr = 2'(s); #1;
      e = {m_to[s], 3'b000, m_cfg[s]};
      checks++;
      if (bus.o_cfg_data !== e) begin failures++; $display("FAIL b2b_cfg%0d i=%0d got=%h exp=%h", s, i, bus.o_cfg_data, e); end
    end
  endtask

  task automatic test_reset_mid_ready();
    logic [7:0] e;
    cfg_write(2'd3, 8'h0C);
    @(negedge clk);
    bus.i_addr = 8'hC0; bus.i_m1_n = 1'b1; bus.i_dev_ready = 4'h0; bus.i_iorq_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_wait !== 1'b1) begin failures++; $display("FAIL midready_wait got=%b exp=1", bus.o_wait); end
    rst = 1'b1; #1;
    checks += 3;
    if (bus.o_wait !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b exp=0", bus.o_wait); end
    if (bus.o_dev_cs_n !== 4'hF) begin failures++; $display("FAIL rst_cs got=%b exp=1111", bus.o_dev_cs_n); end
    if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.o_busy); end
    bus.i_iorq_n = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.i_cfg_addr = 2'd3; #1;
    e = {m_to[3], 3'b000, m_cfg[3]};
    checks += 2;
    if (bus.o_cfg_data !== e) begin failures++; $display("FAIL rst_cfg3 got=%h exp=%h", bus.o_cfg_data, e); end
    if (bus.o_device !== m_dev) begin failures++; $display("FAIL rst_dev got=%0d exp=%0d", bus.o_device, m_dev); end
    run_txn(8'hC0, 1'b1, 3, 99, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_iorq_n = 1'b1; bus.i_m1_n = 1'b1; bus.i_addr = 8'h00; bus.i_dev_ready = 4'h0;
    bus.i_cfg_cs_n = 1'b1; bus.i_cfg_wr_n = 1'b1; bus.i_cfg_addr = 2'd0; bus.i_cfg_data = 8'h00;
    test_reset();
    test_wait_states();
    test_ready();
    test_timeout();
    test_disabled_intack();
    test_abort();
    test_back_to_back();
    test_reset_mid_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
